// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forwarding-mux selects and MUL/DIV sequencer states.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/fwd_sel.sv
// Operand-forwarding select for one EX source register; MEM result wins over WB, x0 never forwards.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output fwd_sel_e          sel
);

  logic hit_m;
  logic hit_w;

  always_comb begin
    hit_m = reg_write_m && (rd_m == rs_e) && (rd_m != '0);
    hit_w = reg_write_w && (rd_w == rs_e) && (rd_w != '0);
    sel   = FWD_RF;
    if (hit_m) begin
      sel = FWD_MEM;
    end else if (hit_w) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding selects, load-use/branch stall and flush control,
// and the start/done sequencer (with timeout) for the multi-cycle MUL/DIV unit in EX.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int MD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MdReqE,
  input  logic              MdDone,
  output logic              MdStart,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MdTimeout
);

  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_TIMEOUT);

  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e       (Rs1E),
    .rd_m       (RdM),
    .rd_w       (RdW),
    .reg_write_m(RegWriteM),
    .reg_write_w(RegWriteW),
    .sel        (fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e       (Rs2E),
    .rd_m       (RdM),
    .rd_w       (RdW),
    .reg_write_m(RegWriteM),
    .reg_write_w(RegWriteW),
    .sel        (fwd_b)
  );

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issued_q, issued_d;
  logic             md_start_q, md_start_d;
  logic             md_timeout_q, md_timeout_d;

  logic issue;
  logic md_busy;
  logic md_hold;
  logic lw_stall;

  always_comb begin
    issue    = (state_q == MD_IDLE) && MdReqE && !issued_q;
    md_busy  = (state_q == MD_BUSY) && !MdDone;
    md_hold  = md_busy || issue;
    lw_stall = LoadE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    issued_d     = issued_q;
    md_start_d   = 1'b0;
    md_timeout_d = md_timeout_q;
    unique case (state_q)
      MD_IDLE: begin
        if (issue) begin
          state_d    = MD_BUSY;
          cnt_d      = '0;
          issued_d   = 1'b1;
          md_start_d = 1'b1;
        end else begin
          // Idle and not issuing means EX advances this edge, so the flag belongs to a retired op.
          issued_d = 1'b0;
        end
      end
      MD_BUSY: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (MdDone) begin
          state_d = MD_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          md_timeout_d = 1'b1;
          state_d      = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= MD_IDLE;
      cnt_q        <= '0;
      issued_q     <= 1'b0;
      md_start_q   <= 1'b0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      issued_q     <= issued_d;
      md_start_q   <= md_start_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  // A held EX stage must never be cleared, so the MUL/DIV hold masks both branch and load-use flushes.
  always_comb begin
    StallF    = lw_stall || md_hold;
    StallD    = lw_stall || md_hold;
    StallE    = md_hold;
    FlushD    = PCSrcE && !md_hold;
    FlushE    = (lw_stall || PCSrcE) && !md_hold;
    FlushM    = md_hold;
    MdStart   = md_start_q;
    MdTimeout = md_timeout_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push hand-computed outputs, a negedge monitor compares.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int REG_AW = 5;
  localparam int MD_TO  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteM, RegWriteW, LoadE, PCSrcE, MdReqE, MdDone;
  logic              MdStart, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdTimeout;
  logic [1:0]        ForwardAE, ForwardBE;

  hazard_ctrl #(.REG_AW(REG_AW), .MD_TIMEOUT(MD_TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .Rs1D     (Rs1D),
    .Rs2D     (Rs2D),
    .Rs1E     (Rs1E),
    .Rs2E     (Rs2E),
    .RdE      (RdE),
    .RdM      (RdM),
    .RdW      (RdW),
    .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .LoadE    (LoadE),
    .PCSrcE   (PCSrcE),
    .MdReqE   (MdReqE),
    .MdDone   (MdDone),
    .MdStart  (MdStart),
    .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE),
    .StallF   (StallF),
    .StallD   (StallD),
    .StallE   (StallE),
    .FlushD   (FlushD),
    .FlushE   (FlushE),
    .FlushM   (FlushM),
    .MdTimeout(MdTimeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic sf, sd, se, fd, fe, fm, ms, mt;
  } out_t;

  out_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;
  out_t  act, e_cur;
  string n_cur;
  logic  prev_ms = 1'b0;

  always_comb begin
    act.fa = ForwardAE; act.fb = ForwardBE;
    act.sf = StallF;    act.sd = StallD;  act.se = StallE;
    act.fd = FlushD;    act.fe = FlushE;  act.fm = FlushM;
    act.ms = MdStart;   act.mt = MdTimeout;
  end

  // Monitor: one expected entry per stimulus cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      n_cur = name_q.pop_front();
      checks++;
      if (act !== e_cur) begin
        failures++;
        $display("FAIL %s got fa=%b fb=%b sf%b sd%b se%b fd%b fe%b fm%b ms%b mt%b want fa=%b fb=%b sf%b sd%b se%b fd%b fe%b fm%b ms%b mt%b",
                 n_cur, act.fa, act.fb, act.sf, act.sd, act.se, act.fd, act.fe, act.fm, act.ms, act.mt,
                 e_cur.fa, e_cur.fb, e_cur.sf, e_cur.sd, e_cur.se, e_cur.fd, e_cur.fe, e_cur.fm, e_cur.ms, e_cur.mt);
      end
    end
    if (!reset) begin
      checks++;
      if (FlushE && StallE) begin
        failures++;
        $display("FAIL flushE_stallE got FlushE=%b StallE=%b want not both 1", FlushE, StallE);
      end
      checks++;
      if (MdStart && prev_ms) begin
        failures++;
        $display("FAIL mdstart_pulse got MdStart=1 on 2 consecutive cycles want single pulse");
      end
    end
    prev_ms = reset ? 1'b0 : MdStart;
  end

  function automatic out_t o(input logic [1:0] fa, input logic [1:0] fb,
                             input logic sf, input logic sd, input logic se, input logic fd,
                             input logic fe, input logic fm, input logic ms, input logic mt);
    out_t r;
    r.fa = fa; r.fb = fb; r.sf = sf; r.sd = sd; r.se = se;
    r.fd = fd; r.fe = fe; r.fm = fm; r.ms = ms; r.mt = mt;
    return r;
  endfunction

  task automatic clr();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0; PCSrcE = 1'b0;
    MdReqE = 1'b0; MdDone = 1'b0;
  endtask

  task automatic cyc(input string nm, input out_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no end of stimulus want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    @(posedge clk); #1;
    cyc("reset_state", o(0,0,0,0,0,0,0,0,0,0));
    reset = 1'b0;

    // Forwarding
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 3;
    cyc("fwd_mem", o(2,0,0,0,0,0,0,0,0,0));
    RegWriteM = 0;
    cyc("fwd_wb", o(1,0,0,0,0,0,0,0,0,0));
    RdM = 0; RdW = 0;
    cyc("fwd_rd0", o(0,0,0,0,0,0,0,0,0,0));
    RegWriteM = 1; RegWriteW = 1; Rs1E = 0; Rs2E = 0;
    cyc("fwd_x0", o(0,0,0,0,0,0,0,0,0,0));
    Rs1E = 4; RdM = 4; Rs2E = 9; RdW = 9;
    cyc("fwd_split", o(2,1,0,0,0,0,0,0,0,0));
    Rs2E = 4; RdW = 4;
    cyc("fwd_mem_prio", o(2,2,0,0,0,0,0,0,0,0));

    // Load-use
    clr(); LoadE = 1; RdE = 7; Rs2D = 7;
    cyc("lu_rs2", o(0,0,1,1,0,0,1,0,0,0));
    clr();
    cyc("lu_bubble", o(0,0,0,0,0,0,0,0,0,0));
    LoadE = 1; RdE = 7; Rs1D = 7;
    cyc("lu_rs1", o(0,0,1,1,0,0,1,0,0,0));
    clr(); LoadE = 1; RdE = 0;
    cyc("lu_rd0", o(0,0,0,0,0,0,0,0,0,0));
    clr(); RdE = 7; Rs1D = 7;
    cyc("lu_noload", o(0,0,0,0,0,0,0,0,0,0));

    // Branch
    clr(); PCSrcE = 1;
    cyc("br", o(0,0,0,0,0,1,1,0,0,0));
    LoadE = 1; RdE = 7; Rs1D = 7;
    cyc("br_lu", o(0,0,1,1,0,1,1,0,0,0));

    // MUL/DIV with MdDone at cycle 4
    clr(); MdReqE = 1;
    cyc("md_c0_issue", o(0,0,1,1,1,0,0,1,0,0));
    cyc("md_c1_start", o(0,0,1,1,1,0,0,1,1,0));
    PCSrcE = 1; LoadE = 1; RdE = 7; Rs1D = 7;
    cyc("md_c2_hold_prio", o(0,0,1,1,1,0,0,1,0,0));
    PCSrcE = 0; LoadE = 0; RdE = 0; Rs1D = 0;
    cyc("md_c3_hold", o(0,0,1,1,1,0,0,1,0,0));
    MdDone = 1;
    cyc("md_c4_done", o(0,0,0,0,0,0,0,0,0,0));
    MdDone = 0;
    cyc("md_c5_noreissue", o(0,0,0,0,0,0,0,0,0,0));
    MdReqE = 0;
    cyc("md_c6_idle", o(0,0,0,0,0,0,0,0,0,0));

    // Timeout: MdDone never comes
    MdReqE = 1;
    cyc("to_c0_issue", o(0,0,1,1,1,0,0,1,0,0));
    cyc("to_c1_start", o(0,0,1,1,1,0,0,1,1,0));
    for (int i = 2; i <= MD_TO + 1; i++) begin
      cyc($sformatf("to_c%0d_hold", i), o(0,0,1,1,1,0,0,1,0,0));
    end
    cyc("to_flag_release", o(0,0,0,0,0,0,0,0,0,1));
    MdReqE = 0;
    cyc("to_sticky", o(0,0,0,0,0,0,0,0,0,1));

    // Asynchronous reset mid-operation
    MdReqE = 1;
    cyc("rst_c0_issue", o(0,0,1,1,1,0,0,1,0,1));
    #2;
    reset = 1'b1; MdReqE = 0;
    cyc("rst_async_mid", o(0,0,0,0,0,0,0,0,0,0));
    cyc("rst_held", o(0,0,0,0,0,0,0,0,0,0));
    reset = 1'b0;
    cyc("rst_after", o(0,0,0,0,0,0,0,0,0,0));

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
